// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
// Ports: a, b, bin in; diff, bout out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, one bit per clock, LSB first.
// Ports: clk, rst_n, start, a, b in; busy, done, diff, borrow, ovf out.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic last;
  logic bit_d;
  logic bit_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .diff (bit_d),
    .bout (bit_bout)
  );

  // start is only honoured outside SHIFT
  assign accept = start && (state_q != SHIFT);
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == SHIFT): busy = 1'b1;
      (state_q == DONE):  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      br_d    = 1'b0;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (state_q == SHIFT) begin
      // operands shift right so bit 0 is always the current bit
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = bit_bout;
      res_d = {bit_d, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        // bit_d is the result MSB on the final step
        diff_d   = {bit_d, res_q[WIDTH-1:1]};
        borrow_d = bit_bout;
        ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Covers reset, vectors, ignored start, reset abort, back-to-back.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8),
    .ovf    (ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4),
    .ovf    (ovf4)
  );

  // Issues one op on the 8-bit DUT; edges counts the accept edge as 1.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int edges);
    @(negedge clk);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    edges = 1;
    while (!done8 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    int edges;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      fails++;
      $display("FAIL reset8 got %h want 000",
               {busy8, done8, diff8, borrow8, ovf8});
    end
    tests++;
    if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h00) begin
      fails++;
      $display("FAIL reset4 got %h want 00",
               {busy4, done4, diff4, borrow4, ovf4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h09;
    b8 = 8'h04;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    tests++;
    if (busy8 !== 1'b1) begin
      fails++;
      $display("FAIL first_edge_start busy got %b want 1", busy8);
    end
    edges = 1;
    while (!done8 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests++;
    if (edges !== 9 || diff8 !== 8'h05) begin
      fails++;
      $display("FAIL first_op edges %0d diff %h want 9 05",
               edges, diff8);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F, 8'h5A};
    logic [7:0] vb [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF, 8'h5A};
    logic [7:0] vd [6] = '{8'h02, 8'hFE, 8'h7F, 8'h01, 8'h80, 8'h00};
    logic       vbr[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       vov[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int edges;
    for (int i = 0; i < 6; i++) begin
      run8(va[i], vb[i], edges);
      tests++;
      if (edges !== 9) begin
        fails++;
        $display("FAIL latency[%0d] got %0d want 9", i, edges);
      end
      tests++;
      if ({diff8, borrow8, ovf8} !== {vd[i], vbr[i], vov[i]}) begin
        fails++;
        $display("FAIL vec[%0d] diff/br/ovf got %h %b %b want %h %b %b",
                 i, diff8, borrow8, ovf8, vd[i], vbr[i], vov[i]);
      end
      tests++;
      if (busy8 !== 1'b0) begin
        fails++;
        $display("FAIL busy_in_done[%0d] got %b want 0", i, busy8);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse[%0d] done %b busy %b want 0 0",
                 i, done8, busy8);
      end
    end
  endtask

  task automatic test_hold();
    int edges;
    run8(8'h20, 8'h01, edges);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (diff8 !== 8'h1F || borrow8 !== 1'b0) begin
      fails++;
      $display("FAIL hold_idle got %h %b want 1f 0", diff8, borrow8);
    end
    @(negedge clk);
    a8 = 8'h01;
    b8 = 8'h02;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy8 !== 1'b1 || diff8 !== 8'h1F || borrow8 !== 1'b0) begin
      fails++;
      $display("FAIL hold_shift got %b %h %b want 1 1f 0",
               busy8, diff8, borrow8);
    end
    edges = 4;
    while (!done8 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests++;
    if (edges !== 9 || diff8 !== 8'hFF || borrow8 !== 1'b1) begin
      fails++;
      $display("FAIL hold_next got %0d %h %b want 9 ff 1",
               edges, diff8, borrow8);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int first;
    logic [9:0] res;
    ndone = 0;
    first = 0;
    res = '0;
    @(negedge clk);
    a8 = 8'h20;
    b8 = 8'h05;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int n = 2; n <= 21; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin
        a8 = 8'hFF;
        b8 = 8'h01;
        start8 = 1'b1;
      end
      if (n == 4) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (first == 0) begin
          first = n;
          res = {diff8, borrow8, ovf8};
        end
      end
    end
    tests++;
    if (ndone !== 1 || first !== 9) begin
      fails++;
      $display("FAIL ignore_count dones %0d at %0d want 1 at 9",
               ndone, first);
    end
    tests++;
    if (res !== {8'h1B, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ignore_result got %h want %h", res,
               {8'h1B, 2'b00});
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int edges;
    ndone = 0;
    run8(8'hF0, 8'h0F, edges);
    @(negedge clk);
    a8 = 8'h05;
    b8 = 8'h03;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      fails++;
      $display("FAIL abort_clear got %h want 000",
               {busy8, done8, diff8, borrow8, ovf8});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done8) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL abort_no_done got %0d want 0", ndone);
    end
    run8(8'h44, 8'h11, edges);
    tests++;
    if (edges !== 9 || {diff8, borrow8, ovf8} !== {8'h33, 2'b00}) begin
      fails++;
      $display("FAIL after_abort got %0d %h %b %b want 9 33 0 0",
               edges, diff8, borrow8, ovf8);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    int sa, sb, r;
    logic [3:0] ed;
    logic eb, eo;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      edges = 1;
      while (!done4 && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
      end
      sa = (i >> 4) >= 8 ? (i >> 4) - 16 : (i >> 4);
      sb = (i & 15) >= 8 ? (i & 15) - 16 : (i & 15);
      r = sa - sb;
      ed = 4'(((i >> 4) - (i & 15) + 16) % 16);
      eb = ((i >> 4) < (i & 15));
      eo = (r < -8) || (r > 7);
      tests++;
      if (edges !== 5 || {diff4, borrow4, ovf4} !== {ed, eb, eo}) begin
        fails++;
        bad++;
        if (bad < 8)
          $display("FAIL w4 a=%h b=%h got %0d %h %b %b want 5 %h %b %b",
                   4'(i >> 4), 4'(i), edges, diff4, borrow4, ovf4,
                   ed, eb, eo);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      fails++;
      $display("FAIL w4_idle done %b busy %b want 0 0", done4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH bits: the minuend, sampled only in the cycle start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: the subtrahend, sampled only in the cycle start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse that marks result valid.
REQ-009 SHALL have port diff, output, WIDTH bits: the result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: final borrow-out; 1 exactly when a<b unsigned.
REQ-011 SHALL have port ovf, output, 1 bit: signed overflow of a-b, treating a and b as two's complement.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance: latch a and b, clear the internal borrow flop, clear the bit counter, and enter SHIFT.
REQ-014 SHALL, in each SHIFT cycle, process one bit LSB-first:
  - d_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i is shifted into the result register from the MSB side.
REQ-015 SHALL remain in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-016 SHALL, on entry to DONE: load diff, set borrow to the final br, and set ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), all in the same edge.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE; latency from the start-accept edge to done high is WIDTH+1 edges.
REQ-018 SHALL hold busy high from the edge after start is accepted through the last SHIFT cycle, and low in IDLE and DONE.
REQ-019 SHALL ignore start while in SHIFT, with no effect on the latched operands, counter or outputs.
REQ-020 SHALL, if start is asserted in DONE, accept it as in IDLE (back-to-back operation); otherwise DONE returns to IDLE.
REQ-021 SHALL hold diff, borrow and ovf stable from one DONE until the next DONE, including through IDLE and SHIFT.
REQ-022 SHALL size the bit counter as $clog2(WIDTH+1) bits, with no wrap-around inside an operation.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, force:
  - state to IDLE
  - busy=0, done=0, diff=0, borrow=0, ovf=0
  - counter, operand and borrow registers to 0
REQ-024 SHALL abort any in-progress operation on reset, with no done pulse produced for it.
REQ-025 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) in the shared package sub_pkg, together with the default WIDTH constant.
REQ-027 SHALL instantiate exactly one combinational sub-module, full_subtractor (ports a, b, bin, diff, bout), for the per-bit step.

Verification
REQ-028 SHALL pass these directed scenarios with WIDTH=8:
  - a=0x05, b=0x03, start -> done 9 edges later; diff=0x02, borrow=0, ovf=0.
  - a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0.
  - a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
  - a=0x00, b=0xFF -> diff=0x01, borrow=1, ovf=0.
  - start pulsed in SHIFT cycle 3 with new operands -> ignored; original result is produced and only one done pulse occurs.
  - rst_n low during SHIFT cycle 4 -> all outputs 0 immediately, no done pulse; the next start runs normally.
REQ-029 SHALL pass an exhaustive run with WIDTH=4: all 256 (a,b) pairs issued back-to-back via start in DONE, each result checked against a reference model computing (a-b) mod 16, a<b, and signed overflow.
